// File: rtl/xadc_model_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : xadc_model_pkg                                               |
// | Description : Shared types and constants for the XADC DRP behavioural      |
// |               model: FSM state encodings, the status/config address        |
// |               boundary and the sample counter width.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package xadc_model_pkg;

  typedef enum logic {
    DRP_IDLE = 1'b0,
    DRP_PEND = 1'b1
  } drp_state_t;

  typedef enum logic {
    SEQ_CONV = 1'b0,
    SEQ_EOC  = 1'b1
  } seq_state_t;

  // Addresses below this are status registers, at or above are config.
  localparam logic [6:0] CFG_BASE_ADDR = 7'h40;

  // Width of the running sample counter stored in each result register.
  localparam int SAMPLE_W = 12;

  // A conversion result is the sample count left-justified in 16 bits.
  function automatic logic [15:0] sample_word(input logic [SAMPLE_W-1:0] cnt);
    return {cnt, 4'h0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/xadc_conv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xadc_conv_seq                                                |
// | Description : Free-running conversion sequencer. Alternates a CONV phase   |
// |               (busy high for CONV_CYCLES cycles) with a one-cycle EOC      |
// |               phase that publishes the result for the current channel.     |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Ports                                                                      |
// |   clk         in   clock, rising edge                                      |
// |   rst_n       in   asynchronous active-low reset                           |
// |   busy        out  conversion in progress                                  |
// |   eoc         out  one-cycle end-of-conversion pulse                       |
// |   eos         out  one-cycle end-of-sequence pulse (with eoc, last ch)     |
// |   channel     out  channel of the latest completed conversion              |
// |   commit_en   out  result write strobe (valid during the EOC cycle)        |
// |   commit_addr out  register address of the result                          |
// |   commit_data out  result value                                            |
// +----------------------------------------------------------------------------+
module xadc_conv_seq #(
  parameter int CONV_CYCLES = 26,
  parameter int NUM_CH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        busy,
  output logic        eoc,
  output logic        eos,
  output logic [4:0]  channel,
  output logic        commit_en,
  output logic [6:0]  commit_addr,
  output logic [15:0] commit_data
);
  import xadc_model_pkg::*;

  localparam logic [7:0] CONV_LAST = 8'(CONV_CYCLES);
  localparam logic [4:0] IDX_LAST  = 5'(NUM_CH - 1);

  seq_state_t          state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [4:0]          idx_q, idx_d;
  logic [4:0]          chan_q, chan_d;
  logic [SAMPLE_W-1:0] smp_q, smp_d;

  // busy is registered so it stays low through reset and rises on the first
  // clock edge after release; cnt counts the busy cycles already issued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    idx_d   = idx_q;
    chan_d  = chan_q;
    smp_d   = smp_q;
    case (state_q)
      SEQ_CONV: begin
        if (cnt_q == CONV_LAST) begin
          state_d = SEQ_EOC;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
          chan_d  = idx_q;
        end else begin
          busy_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      SEQ_EOC: begin
        // Leaving EOC starts the next conversion, so this edge is busy cycle 1.
        state_d = SEQ_CONV;
        busy_d  = 1'b1;
        cnt_d   = 8'd1;
        smp_d   = smp_q + SAMPLE_W'(1);
        idx_d   = (idx_q == IDX_LAST) ? 5'd0 : idx_q + 5'd1;
      end
      default: state_d = SEQ_CONV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_CONV;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      idx_q   <= 5'd0;
      chan_q  <= 5'd0;
      smp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      smp_q   <= smp_d;
    end
  end

  assign busy        = busy_q;
  assign eoc         = (state_q == SEQ_EOC);
  assign eos         = eoc && (idx_q == IDX_LAST);
  assign channel     = chan_q;
  assign commit_en   = eoc;
  assign commit_addr = {2'b00, idx_q};
  assign commit_data = sample_word(smp_q);

endmodule
`default_nettype wire

// File: rtl/xadc_drp_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xadc_drp_model                                               |
// | Description : Behavioural model of the XADC dynamic reconfiguration port.  |
// |               128x16 register file behind a fixed-latency DRP handshake,   |
// |               fed by a free-running conversion sequencer.                  |
// | Revision    : 1.0 - initial release                                        |
// | Build option: XADC_MODEL_WRPROT_EN - when defined, DRP writes to the       |
// |               status range 0x00-0x3F are silently discarded.               |
// |                                                                            |
// | Ports                                                                      |
// |   clk          in   clock, rising edge                                     |
// |   rst_n        in   asynchronous active-low reset                          |
// |   den          in   DRP enable, one-cycle request pulse                    |
// |   dwe          in   write enable, sampled with den                         |
// |   daddr[6:0]   in   register address, sampled with den                     |
// |   din[15:0]    in   write data, sampled with den                           |
// |   dout[15:0]   out  read data, non-zero only during drdy of a read         |
// |   drdy         out  one-cycle completion pulse                            |
// |   busy         out  conversion in progress                                |
// |   eoc          out  end-of-conversion pulse                               |
// |   eos          out  end-of-sequence pulse                                 |
// |   channel[4:0] out  channel of the latest completed conversion            |
// |   jtaglocked   out  constant 0                                            |
// |   protocol_err out  pulse the cycle after a rejected den                  |
// +----------------------------------------------------------------------------+
module xadc_drp_model #(
  parameter int DRP_LATENCY = 4,
  parameter int CONV_CYCLES = 26,
  parameter int NUM_CH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        den,
  input  logic        dwe,
  input  logic [6:0]  daddr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        drdy,
  output logic        busy,
  output logic        eoc,
  output logic        eos,
  output logic [4:0]  channel,
  output logic        jtaglocked,
  output logic        protocol_err
);
  import xadc_model_pkg::*;

  localparam logic [3:0] LAT = 4'(DRP_LATENCY);

  drp_state_t  state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic        wr_q, wr_d;
  logic [15:0] rdata_q;
  logic        perr_q;
  logic [15:0] regs [128];

  logic        accept;
  logic        wr_allowed;
  logic        commit_en;
  logic [6:0]  commit_addr;
  logic [15:0] commit_data;

  xadc_conv_seq #(
    .CONV_CYCLES (CONV_CYCLES),
    .NUM_CH      (NUM_CH)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy        (busy),
    .eoc         (eoc),
    .eos         (eos),
    .channel     (channel),
    .commit_en   (commit_en),
    .commit_addr (commit_addr),
    .commit_data (commit_data)
  );

  assign accept = den && (state_q == DRP_IDLE);

`ifdef XADC_MODEL_WRPROT_EN
  assign wr_allowed = (daddr >= CFG_BASE_ADDR);
`else
  assign wr_allowed = 1'b1;
`endif

  // lat_q holds the cycles remaining including the drdy cycle itself, so
  // drdy is the PEND cycle where it has counted down to 1.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    wr_d    = wr_q;
    case (state_q)
      DRP_IDLE: begin
        if (den) begin
          state_d = DRP_PEND;
          lat_d   = LAT;
          wr_d    = dwe;
        end
      end
      DRP_PEND: begin
        if (lat_q == 4'd1) state_d = DRP_IDLE;
        else               lat_d   = lat_q - 4'd1;
      end
      default: state_d = DRP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRP_IDLE;
      lat_q   <= 4'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      wr_q    <= wr_d;
    end
  end

  // Read capture sees the pre-commit contents. The sequencer write is issued
  // after the DRP write so it takes priority on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 16'h0000;
      perr_q  <= 1'b0;
      for (int i = 0; i < 128; i++) regs[i] <= 16'h0000;
    end else begin
      perr_q <= den && (state_q == DRP_PEND);
      if (accept) begin
        rdata_q <= regs[daddr];
        if (dwe && wr_allowed) regs[daddr] <= din;
      end
      if (commit_en) regs[commit_addr] <= commit_data;
    end
  end

  assign drdy         = (state_q == DRP_PEND) && (lat_q == 4'd1);
  assign dout         = (drdy && !wr_q) ? rdata_q : 16'h0000;
  assign protocol_err = perr_q;
  assign jtaglocked   = 1'b0;

endmodule
`default_nettype wire

// File: doc/xadc_drp_model.md
XADC_DRP_MODEL -- requirements
Module: xadc_drp_model

Interface
REQ-001 SHALL have parameter DRP_LATENCY, default 4, cycles from accepted den to drdy (legal 1..15).
REQ-002 SHALL have parameter CONV_CYCLES, default 26, busy-high cycles per conversion (legal 2..255).
REQ-003 SHALL have parameter NUM_CH, default 4, channels in sequence (legal 1..32).
REQ-004 SHALL have ports, one per line:
  clk  input  1  sole clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  den  input  1  DRP enable, one-cycle request pulse
  dwe  input  1  write enable, sampled with den
  daddr  input  7  register address, sampled with den
  din  input  16  write data, sampled with den
  dout  output  16  read data, valid only while drdy=1
  drdy  output  1  one-cycle completion pulse
  busy  output  1  conversion in progress
  eoc  output  1  one-cycle end-of-conversion pulse
  eos  output  1  one-cycle end-of-sequence pulse
  channel  output  5  channel of the latest completed conversion
  jtaglocked  output  1  constant 0
  protocol_err  output  1  one-cycle pulse on a rejected den

Function
REQ-005 SHALL hold a 128x16 register file indexed by daddr.
REQ-006 DRP FSM SHALL have states IDLE and PEND; den in IDLE is accepted, moves to PEND, loads latency counter with DRP_LATENCY.
REQ-007 Read SHALL capture regfile[daddr] in the accept cycle; write SHALL commit din to regfile[daddr] in the accept cycle (subject to REQ-015).
REQ-008 drdy SHALL pulse exactly DRP_LATENCY cycles after the accept edge; FSM returns to IDLE in the same cycle; den in that drdy cycle is rejected.
REQ-009 dout SHALL equal captured read data during drdy of a read, and 0 at all other times, including drdy of a write.
REQ-010 den while in PEND SHALL be ignored (no regfile change, no extra drdy) and SHALL pulse protocol_err the next cycle.
REQ-011 Sequencer FSM SHALL have states CONV (busy=1, count CONV_CYCLES) and EOC (busy=0, one cycle), alternating continuously.
REQ-012 In EOC: eoc=1; channel=current index; regfile[index] <= {sample_cnt[11:0],4'h0}; sample_cnt increments, wrapping 0xFFF->0x000.
REQ-013 eos SHALL pulse with eoc when index=NUM_CH-1; index then wraps to 0, otherwise increments.
REQ-014 DRP write and sequencer commit to the same address in the same cycle: sequencer value SHALL win; DRP read of that address in that cycle SHALL return the pre-commit value.

Reset
REQ-015 rst_n low SHALL immediately clear dout, drdy, busy, eoc, eos, channel, protocol_err, sample_cnt, index, regfile, and force DRP FSM to IDLE and sequencer to CONV with count reset; in-flight transaction SHALL be dropped with no drdy.
REQ-016 First clock after rst_n deasserts SHALL start conversion of channel 0 (busy=1 from that edge).

Configuration
REQ-017 With XADC_MODEL_WRPROT_EN defined, DRP writes to addresses 0x00-0x3F SHALL be discarded (drdy still issued, no protocol_err); without it, all 128 addresses SHALL be DRP-writable.

Structure
REQ-018 Package xadc_model_pkg SHALL hold FSM state encodings, status/config address boundary 7'h40, and sample field width 12.
REQ-019 Sequencer SHALL be a sub-module xadc_conv_seq; DRP FSM and regfile stay in the top.

Verification
REQ-020 Reset, wait for first eoc (index 0): busy high 26 cycles then eoc=1, channel=0, busy=0; read 0x00 -> dout=16'h0000 at drdy 4 cycles after den.
REQ-021 After 4 conversions: eos pulses with eoc on channel=3; read 0x03 -> 16'h0030; next eoc shows channel=0.
REQ-022 Write 0x41=16'hBEEF, then read 0x41 -> first drdy with dout=0, second drdy with dout=16'hBEEF.
REQ-023 den at cycles 0 and 2 -> single drdy at cycle 4, protocol_err at cycle 3, second request has no effect.
REQ-024 Write 0x02=16'h1234: with XADC_MODEL_WRPROT_EN read back shows sequencer value; without it read back shows 16'h1234 until next channel-2 eoc.
REQ-025 Drop rst_n 2 cycles after a den -> no drdy, all outputs 0, channel sequence restarts at 0.
